// File: rtl/pl_sysref_gen.sv
// Programmable SYSREF pulse generator in the PL clock domain. It can run continuously or emit
// a fixed-length burst, and can optionally align its first pulse to the captured board SYSREF.
module pl_sysref_gen #(
    parameter int CNT_W = 16,
    parameter int PW_W  = 8,
    parameter int BC_W  = 8
) (
    input  logic             pl_clk,
    input  logic             pl_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [PW_W-1:0]  pulse_width,
    input  logic [BC_W-1:0]  burst_count,
    input  logic             sysref_in,
    output logic             sysref_out,
    output logic             sysref_edge,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [BC_W-1:0]  pulse_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ALIGN = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [BC_W-1:0]  pulse_cnt_next;
    logic             stop_pend, stop_pend_next;
    logic             sysref_in_d;
    logic             done_next, cfg_err_next, edge_next, latch_cfg;
    logic             start_ok, align_edge, burst_end;

    logic             cfg_burst;
    logic [CNT_W-1:0] cfg_period;
    logic [PW_W-1:0]  cfg_pw;
    logic [BC_W-1:0]  cfg_bc;

    assign start_ok = (pulse_width != '0) &&
                      (period > CNT_W'(pulse_width)) &&
                      (!mode[0] || (burst_count != '0));

    // Only a 0->1 transition seen while already waiting counts as an alignment edge.
    assign align_edge = sysref_in && !sysref_in_d;
    assign burst_end  = cfg_burst && (pulse_cnt == cfg_bc);
    assign fsm_state  = state;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pulse_cnt_next = pulse_cnt;
        stop_pend_next = stop_pend;
        done_next      = 1'b0;
        cfg_err_next   = 1'b0;
        edge_next      = 1'b0;
        latch_cfg      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (start_ok) begin
                        latch_cfg      = 1'b1;
                        stop_pend_next = 1'b0;
                        pulse_cnt_next = '0;
                        if (mode[1]) begin
                            state_next = WAIT_ALIGN;
                        end else begin
                            state_next     = HIGH;
                            cnt_next       = CNT_W'(1);
                            pulse_cnt_next = BC_W'(1);
                            edge_next      = 1'b1;
                        end
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end

            WAIT_ALIGN: begin
                if (abort) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                end else if (stop || stop_pend) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                    done_next      = 1'b1;
                end else if (align_edge) begin
                    state_next     = HIGH;
                    cnt_next       = CNT_W'(1);
                    pulse_cnt_next = BC_W'(1);
                    edge_next      = 1'b1;
                end
            end

            HIGH: begin
                if (abort) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                end else begin
                    if (stop) stop_pend_next = 1'b1;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(cfg_pw)) state_next = LOW;
                end
            end

            LOW: begin
                if (abort) begin
                    state_next     = IDLE;
                    stop_pend_next = 1'b0;
                end else if (cnt == cfg_period) begin
                    // Last cycle of the period: either finish cleanly or start the next pulse.
                    if (stop || stop_pend || burst_end) begin
                        state_next     = IDLE;
                        stop_pend_next = 1'b0;
                        done_next      = 1'b1;
                    end else begin
                        state_next     = HIGH;
                        cnt_next       = CNT_W'(1);
                        edge_next      = 1'b1;
                        pulse_cnt_next = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + BC_W'(1);
                    end
                end else begin
                    if (stop) stop_pend_next = 1'b1;
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next     = IDLE;
                stop_pend_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pulse_cnt   <= '0;
            stop_pend   <= 1'b0;
            sysref_in_d <= 1'b0;
            sysref_out  <= 1'b0;
            sysref_edge <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pulse_cnt   <= pulse_cnt_next;
            stop_pend   <= stop_pend_next;
            sysref_in_d <= sysref_in;
            // Outputs are decoded from the next state so they line up with the state they describe.
            sysref_out  <= (state_next == HIGH);
            sysref_edge <= edge_next;
            busy        <= (state_next != IDLE);
            done        <= done_next;
            cfg_err     <= cfg_err_next;
        end
    end

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            cfg_burst  <= 1'b0;
            cfg_period <= '0;
            cfg_pw     <= '0;
            cfg_bc     <= '0;
        end else if (latch_cfg) begin
            cfg_burst  <= mode[0];
            cfg_period <= period;
            cfg_pw     <= pulse_width;
            cfg_bc     <= burst_count;
        end
    end

endmodule

// File: tb/tb_pl_sysref_gen.sv
// Directed bench for pl_sysref_gen: each run records per-cycle output bit vectors
// (bit c = value in cycle c, start in cycle 0) and compares them with hand-derived patterns.
module tb_pl_sysref_gen;

    logic        pl_clk;
    logic        pl_rst;
    logic        start, stop, abort;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [7:0]  pulse_width;
    logic [7:0]  burst_count;
    logic        sysref_in;
    logic        sysref_out, sysref_edge, busy, done, cfg_err;
    logic [7:0]  pulse_cnt;
    logic [1:0]  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] out_v, edge_v, busy_v, done_v, err_v;

    pl_sysref_gen #(.CNT_W(16), .PW_W(8), .BC_W(8)) dut (
        .pl_clk      (pl_clk),
        .pl_rst      (pl_rst),
        .start       (start),
        .stop        (stop),
        .abort       (abort),
        .mode        (mode),
        .period      (period),
        .pulse_width (pulse_width),
        .burst_count (burst_count),
        .sysref_in   (sysref_in),
        .sysref_out  (sysref_out),
        .sysref_edge (sysref_edge),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .pulse_cnt   (pulse_cnt),
        .fsm_state   (fsm_state)
    );

    initial begin
        pl_clk = 1'b0;
        forever #5 pl_clk = ~pl_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pl_clk);
        #1;
    endtask

    // start in cycle 0 (and again in start2_at, with changed config that must be ignored)
    task automatic run(input int n, input int stop_at, input int abort_at,
                       input int start2_at, input logic [31:0] sref);
        out_v = '0; edge_v = '0; busy_v = '0; done_v = '0; err_v = '0;
        for (int c = 0; c < n; c++) begin
            start     = (c == 0) || (c == start2_at);
            stop      = (c == stop_at);
            abort     = (c == abort_at);
            sysref_in = sref[c];
            if (c == start2_at) begin
                period      = 16'd3;
                pulse_width = 8'd1;
            end
            out_v[c]  = sysref_out;
            edge_v[c] = sysref_edge;
            busy_v[c] = busy;
            done_v[c] = done;
            err_v[c]  = cfg_err;
            step();
        end
        start = 1'b0; stop = 1'b0; abort = 1'b0; sysref_in = 1'b0;
    endtask

    task automatic kill();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic cfg(input logic [1:0] m, input int per, input int pw, input int bc);
        mode        = m;
        period      = 16'(per);
        pulse_width = 8'(pw);
        burst_count = 8'(bc);
    endtask

    task automatic continuous_8_2(input string tag);
        cfg(2'b00, 8, 2, 0);
        run(24, -1, -1, -1, 32'h0);
        check({tag, "_out"},  out_v,  32'h0006_0606);
        check({tag, "_edge"}, edge_v, 32'h0002_0202);
        check({tag, "_busy"}, busy_v, 32'h00FF_FFFE);
        check({tag, "_done"}, done_v, 32'h0);
        check({tag, "_cnt"},  32'(pulse_cnt), 32'd3);
        kill();
        check({tag, "_abort_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_abort_out"},  {31'b0, sysref_out}, 32'd0);
        check({tag, "_abort_cnt"},  32'(pulse_cnt), 32'd3);
    endtask

    initial begin
        pl_rst = 1'b1;
        start = 1'b0; stop = 1'b0; abort = 1'b0; sysref_in = 1'b0;
        cfg(2'b00, 8, 2, 0);
        repeat (3) @(posedge pl_clk);
        #1 pl_rst = 1'b0;
        check("rst_out",   {31'b0, sysref_out}, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_cnt",   32'(pulse_cnt), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        step();

        continuous_8_2("cont");

        // burst of 3, period 5, width 1
        cfg(2'b01, 5, 1, 3);
        run(20, -1, -1, -1, 32'h0);
        check("burst_out",  out_v,  32'h0000_0842);
        check("burst_edge", edge_v, 32'h0000_0842);
        check("burst_busy", busy_v, 32'h0000_FFFE);
        check("burst_done", done_v, 32'h0001_0000);
        check("burst_cnt",  32'(pulse_cnt), 32'd3);

        // aligned start: edge in cycle 0 ignored, edge in cycle 10 aligns
        cfg(2'b10, 8, 2, 0);
        run(24, -1, -1, -1, 32'h0000_1C01);
        check("align_out",  out_v,  32'h0018_1800);
        check("align_edge", edge_v, 32'h0008_0800);
        check("align_busy", busy_v, 32'h00FF_FFFE);
        check("align_cnt",  32'(pulse_cnt), 32'd2);
        kill();

        // stop while waiting for alignment
        cfg(2'b10, 8, 2, 0);
        run(8, 3, -1, -1, 32'h0);
        check("walign_stop_busy", busy_v, 32'h0000_000E);
        check("walign_stop_done", done_v, 32'h0000_0010);
        check("walign_stop_out",  out_v,  32'h0);

        // rejected configurations
        cfg(2'b00, 8, 0, 0);
        run(4, -1, -1, -1, 32'h0);
        check("err_pw0",      err_v,  32'h2);
        check("err_pw0_busy", busy_v | out_v, 32'h0);
        cfg(2'b00, 4, 4, 0);
        run(4, -1, -1, -1, 32'h0);
        check("err_per_eq_pw",      err_v,  32'h2);
        check("err_per_eq_pw_busy", busy_v | out_v, 32'h0);
        cfg(2'b01, 8, 2, 0);
        run(4, -1, -1, -1, 32'h0);
        check("err_bc0",      err_v,  32'h2);
        check("err_bc0_busy", busy_v | out_v, 32'h0);

        // smallest legal period: period = pulse_width + 1
        cfg(2'b00, 3, 2, 0);
        run(10, -1, -1, -1, 32'h0);
        check("minper_out",  out_v,  32'h0000_01B6);
        check("minper_edge", edge_v, 32'h0000_0092);
        check("minper_err",  err_v,  32'h0);
        kill();

        // graceful stop during the first pulse
        cfg(2'b00, 8, 4, 0);
        run(16, 2, -1, -1, 32'h0);
        check("stop_out",  out_v,  32'h0000_001E);
        check("stop_busy", busy_v, 32'h0000_01FE);
        check("stop_done", done_v, 32'h0000_0200);

        // abort during the first pulse
        cfg(2'b00, 8, 4, 0);
        run(8, -1, 2, -1, 32'h0);
        check("abort_out",  out_v,  32'h0000_0006);
        check("abort_busy", busy_v, 32'h0000_0006);
        check("abort_done", done_v, 32'h0);
        check("abort_cnt",  32'(pulse_cnt), 32'd1);

        // start while busy (with different config) is ignored
        cfg(2'b00, 8, 4, 0);
        run(20, 12, -1, 5, 32'h0);
        check("rebusy_out",  out_v,  32'h0000_1E1E);
        check("rebusy_busy", busy_v, 32'h0001_FFFE);
        check("rebusy_done", done_v, 32'h0002_0000);
        check("rebusy_err",  err_v,  32'h0);
        check("rebusy_cnt",  32'(pulse_cnt), 32'd2);

        // asynchronous reset in the middle of a pulse
        cfg(2'b00, 8, 2, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("midrst_pre_out", {31'b0, sysref_out}, 32'd1);
        #2 pl_rst = 1'b1;
        #1;
        check("midrst_out",  {31'b0, sysref_out}, 32'd0);
        check("midrst_edge", {31'b0, sysref_edge}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_cnt",  32'(pulse_cnt), 32'd0);
        #2 pl_rst = 1'b0;
        step();
        continuous_8_2("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pl_sysref_gen.md
Name: pl_sysref_gen

Overview:
- Generates a programmable SYSREF pulse train in the PL clock domain. It is the transmit counterpart of the PL SYSREF capture path.
- Drives the SYSREF input of downstream converters or a loopback test path.
- Optionally phase-aligns its first pulse to the rising edge of the captured board SYSREF (sysref_in, already synchronous to pl_clk).
- Supports continuous and fixed-length burst modes, with graceful stop and immediate abort.

Parameters:
CNT_W, 16, width of period counter and period input
PW_W, 8, width of pulse_width input
BC_W, 8, width of burst_count input and pulse_cnt output

Ports:
pl_clk  in  1  PL fabric clock; all logic on rising edge
pl_rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; samples configuration
stop  in  1  graceful stop; ends after the current period completes
abort  in  1  immediate stop
mode  in  2  bit0: 1=burst, 0=continuous; bit1: 1=wait for sysref_in rising edge before first pulse
period  in  CNT_W  cycles from one rising edge of sysref_out to the next
pulse_width  in  PW_W  high time of each pulse, in cycles
burst_count  in  BC_W  number of pulses in burst mode
sysref_in  in  1  captured SYSREF, synchronous to pl_clk
sysref_out  out  1  generated SYSREF, registered
sysref_edge  out  1  one-cycle strobe coincident with the first high cycle of each pulse
busy  out  1  high from the cycle after an accepted start until generation ends
done  out  1  one-cycle strobe on normal completion (burst end or stop)
cfg_err  out  1  one-cycle strobe when start is rejected
pulse_cnt  out  BC_W  pulses emitted since the last accepted start; saturates at all-ones

Behaviour:
- Reset (async, pl_rst=1): state IDLE; sysref_out, sysref_edge, busy, done, cfg_err = 0; pulse_cnt = 0; sysref_in_d = 0. Outputs go to 0 immediately on assertion, not at the next edge.
- All outputs are registered; no combinational input-to-output paths.
- Configuration (mode, period, pulse_width, burst_count) is latched on an accepted start. Later input changes are ignored until the next start.
- Start validity (evaluated in IDLE only): pulse_width>=1, period>pulse_width, and (mode[0]=0 or burst_count>=1).
  - Invalid start: cfg_err=1 in the next cycle; state stays IDLE; busy stays 0.
- Start while busy: ignored, with no cfg_err.
- States:
  - IDLE
  - WAIT_ALIGN
  - HIGH
  - LOW
- Transitions:
  - IDLE --valid start, mode[1]=0--> HIGH. sysref_out=1 in cycle N+1, where start is sampled in cycle N. pulse_cnt is reset to 1.
  - IDLE --valid start, mode[1]=1--> WAIT_ALIGN.
  - WAIT_ALIGN --sysref_in=1 and sysref_in_d=0 sampled--> HIGH on the next cycle. Only edges sampled while in WAIT_ALIGN count; an edge sampled in the start cycle is ignored.
  - HIGH: phase counter runs 1..pulse_width, then moves to LOW.
  - LOW: phase counter continues up to period, then either:
    - returns to HIGH with counter=1 and pulse_cnt+1, or
    - goes to IDLE if an end condition holds.
- End conditions, evaluated at the last LOW cycle:
  - burst mode and pulse_cnt==burst_count, or
  - a stop request is pending.
  - On end: done=1 and busy=0 in the following cycle. Simultaneous burst-end and stop produce one done.
- Stop is latched as pending in any busy state and cleared on exit.
  - Stop in WAIT_ALIGN: return to IDLE next cycle with done=1.
  - Pulses are never truncated by stop.
- Abort has priority over stop and start.
  - In any busy state: next cycle is IDLE, with sysref_out=0 and busy=0.
  - No done is issued; pulse_cnt holds its value.
- sysref_edge is 1 only in the first HIGH cycle of each pulse.
- The phase counter is CNT_W bits and never wraps, because period <= 2^CNT_W-1.
- sysref_in_d samples sysref_in every cycle, in all states.

Test Plan:
- Continuous, period=8, pulse_width=2, start at cycle 0 -> sysref_out high in cycles 1-2, 9-10, 17-18; sysref_edge at 1, 9, 17; busy high from cycle 1.
- Burst, mode=01, period=5, pulse_width=1, burst_count=3, start at 0 -> sysref_out high at cycles 1, 6, 11; done=1 and busy=0 at cycle 16; pulse_cnt=3.
- Aligned, mode=10, start at 0, sysref_in rises (sampled) at cycle 10 -> sysref_out first high at cycle 11; an additional sysref_in edge at cycle 0 is ignored.
- Config errors -> cfg_err pulses once, busy=0, sysref_out=0 for each of:
  - pulse_width=0
  - period=pulse_width=4
  - burst mode with burst_count=0
- Stop and abort, continuous, period=8, pulse_width=4:
  - stop at cycle 2 -> pulse completes, low phase runs to cycle 8, done at 9, no further pulse.
  - abort at cycle 2 -> sysref_out=0 at cycle 3, no done.
  - start during busy -> ignored.
- Reset mid-pulse: assert pl_rst asynchronously while sysref_out=1 -> all outputs 0 before the next pl_clk edge; after release, a new start behaves as in the first test.
